// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the shared-memory datapath controls; counts retired instructions.
module multicycle_control #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired,
  output logic               illegal_seen
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    RWB    = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     cur, nxt;
  logic [5:0] op_q;
  logic       rdy;
  logic       retire;
  logic       illegal;

  assign rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state = STATE_W'(cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= IDLE;
      op_q         <= 6'd0;
      retired      <= '0;
      illegal_seen <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
      if (illegal) illegal_seen <= 1'b1;
    end
  end

  // Completing states retire on their exit to FETCH; MEMWR only once memory is ready.
  assign retire = (cur == MEMWB) || (cur == RWB) || (cur == ADDIWB) ||
                  (cur == BRANCH) || (cur == JUMP) || ((cur == MEMWR) && rdy);
  assign illegal = (cur == DECODE) && (nxt == FETCH);

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:   nxt = FETCH;
      FETCH:  if (rdy) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = EXEC;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDIEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR: nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (rdy) nxt = MEMWB;
      MEMWR:  if (rdy) nxt = FETCH;
      EXEC:   nxt = RWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, RWB, ADDIWB, BRANCH, JUMP: nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCWrite = rdy;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ADDIWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a path-level reference model checked every cycle on two
// instances (handshake on / 32-bit counter, handshake off / 2-bit counter) plus directed literals.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_in [2];
  logic       mr [2];
  logic [3:0] st [2];

  logic pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rwr0, asa0;
  logic pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rwr1, asa1;
  logic [1:0] asb0, aop0, pcs0, asb1, aop1, pcs1;
  logic [31:0] ret0;
  logic [1:0]  ret1;
  logic        ill0, ill1;
  logic [15:0] ctrl [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(32), .STATE_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(op_in[0]), .mem_ready(mr[0]),
    .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mrd0), .MemWrite(mwr0),
    .IRWrite(irw0), .MemtoReg(m2r0), .RegDst(rdst0), .RegWrite(rwr0), .ALUSrcA(asa0),
    .ALUSrcB(asb0), .ALUOp(aop0), .PCSource(pcs0), .state(st[0]), .retired(ret0),
    .illegal_seen(ill0));

  multicycle_control #(.MEM_HANDSHAKE(0), .CNT_W(2), .STATE_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(op_in[1]), .mem_ready(mr[1]),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1), .MemWrite(mwr1),
    .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rdst1), .RegWrite(rwr1), .ALUSrcA(asa1),
    .ALUSrcB(asb1), .ALUOp(aop1), .PCSource(pcs1), .state(st[1]), .retired(ret1),
    .illegal_seen(ill1));

  assign ctrl[0] = {pcw0, pcwc0, iord0, mrd0, mwr0, irw0, m2r0, rdst0, rwr0, asa0, asb0, aop0, pcs0};
  assign ctrl[1] = {pcw1, pcwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rwr1, asa1, asb1, aop1, pcs1};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Control word expected for each phase, in ctrl[] bit order.
  function automatic logic [15:0] exp_ctrl(input int s, input logic rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (s)
      1:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      2:  asb = 2'b11;
      3, 11: begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rwr = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rwr = 1; rdst = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      12: rwr = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, pcs};
  endfunction

  // Reference model: after DECODE an instruction walks a fixed list of phases;
  // memory phases may stall; finishing the list retires it.
  int m_state [2] = '{0, 0};
  int m_ret   [2] = '{0, 0};
  bit m_ill   [2] = '{0, 0};
  int m_path  [2][3];
  int m_len   [2] = '{0, 0};
  int m_pos   [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_state[i] = 0; m_ret[i] = 0; m_ill[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit rdy;
        rdy = (i == 1) ? 1'b1 : mr[0];
        case (m_state[i])
          0: m_state[i] = 1;
          1: if (rdy) m_state[i] = 2;
          2: begin
            m_pos[i] = 0;
            case (op_in[i])
              6'h00: begin m_path[i] = '{7, 8, 0};  m_len[i] = 2; end
              6'h23: begin m_path[i] = '{3, 4, 5};  m_len[i] = 3; end
              6'h2B: begin m_path[i] = '{3, 6, 0};  m_len[i] = 2; end
              6'h04: begin m_path[i] = '{9, 0, 0};  m_len[i] = 1; end
              6'h02: begin m_path[i] = '{10, 0, 0}; m_len[i] = 1; end
              6'h08: begin m_path[i] = '{11, 12, 0}; m_len[i] = 2; end
              default: m_len[i] = 0;
            endcase
            if (m_len[i] == 0) begin
              m_ill[i] = 1; m_state[i] = 1;
            end else m_state[i] = m_path[i][0];
          end
          default: begin
            if (!((m_state[i] == 4 || m_state[i] == 6) && !rdy)) begin
              m_pos[i]++;
              if (m_pos[i] == m_len[i]) begin
                m_state[i] = 1; m_ret[i]++;
              end else m_state[i] = m_path[i][m_pos[i]];
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("state%0d", i), st[i], m_state[i]);
      chk($sformatf("ctrl%0d", i), ctrl[i], exp_ctrl(m_state[i], (i == 1) ? 1'b1 : mr[0]));
      chk($sformatf("illegal%0d", i), (i == 0) ? ill0 : ill1, m_ill[i]);
    end
    chk("retired0", ret0, m_ret[0]);
    chk("retired1", ret1, m_ret[1] & 3);
  end

  // Runs one instruction starting from the first FETCH cycle; returns FETCH-to-FETCH cycles.
  task automatic do_instr(input int w, input logic [5:0] op, input int stall_st,
                          input int nstall, output int cyc);
    int left;
    int prev;
    int guard;
    left = nstall;
    guard = 0;
    while (st[w] != 4'd1 && guard < 40) begin
      @(posedge clk); #2; guard++;
    end
    if (guard >= 40) chk("fetch_timeout", guard, 0);
    op_in[w] = op;
    cyc = 0;
    prev = 1;
    while (cyc < 60) begin
      if (w == 0) begin
        if (st[0] == stall_st[3:0] && left > 0) begin
          mr[0] = 1'b0; left--;
        end else mr[0] = 1'b1;
      end
      @(posedge clk); #2; cyc++;
      if (st[w] == 4'd1 && prev != 1) break;
      prev = int'(st[w]);
    end
    if (cyc >= 60) chk("instr_timeout", cyc, 0);
  endtask

  initial begin
    int c;
    int trace [5] = '{1, 2, 7, 8, 1};
    int lens [4] = '{4, 3, 3, 4};
    logic [5:0] ops [4] = '{6'h2B, 6'h04, 6'h02, 6'h08};

    rst_n = 1'b0;
    op_in[0] = 6'h00; op_in[1] = 6'h3F;
    mr[0] = 1'b1; mr[1] = 1'b0;
    #12;
    chk("reset_state", st[0], 0);
    chk("reset_ctrl", ctrl[0], 0);
    chk("reset_retired", ret0, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("idle_after_release", st[0], 0);

    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("rtype_trace", st[0], trace[k]);
      if (k == 3) chk("rwb_regwrite_regdst", {rwr0, rdst0}, 2'b11);
    end
    chk("rtype_retired", ret0, 1);

    do_instr(0, 6'h23, 4, 3, c);
    chk("lw_stall_cycles", c, 8);
    chk("lw_retired", ret0, 2);

    for (int k = 0; k < 4; k++) begin
      do_instr(0, ops[k], 0, 0, c);
      chk("b2b_cycles", c, lens[k]);
    end
    chk("b2b_retired", ret0, 6);

    do_instr(0, 6'h3F, 0, 0, c);
    chk("illegal_cycles", c, 2);
    chk("illegal_flag", ill0, 1);
    chk("illegal_no_retire", ret0, 6);
    do_instr(0, 6'h08, 0, 0, c);
    chk("post_illegal_cycles", c, 4);
    chk("post_illegal_retired", ret0, 7);
    chk("illegal_sticky", ill0, 1);

    op_in[0] = 6'h2B;
    mr[0] = 1'b1;
    for (int k = 0; k < 10 && st[0] != 4'd6; k++) begin
      @(posedge clk); #2;
    end
    mr[0] = 1'b0;
    @(posedge clk); #2;
    chk("memwr_stalled", st[0], 6);
    chk("memwr_strobe", mwr0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_state", st[0], 0);
    chk("async_reset_ctrl", ctrl[0], 0);
    chk("async_reset_retired", ret0, 0);
    chk("async_reset_illegal", ill0, 0);
    @(posedge clk); #2;
    chk("held_in_reset", st[0], 0);
    rst_n = 1'b1;
    mr[0] = 1'b1;
    @(posedge clk); #2;
    chk("fetch_after_reset", st[0], 1);

    do_instr(1, 6'h23, 0, 0, c);
    chk("nohs_lw_cycles", c, 5);
    chk("nohs_lw_retired", ret1, 1);
    for (int k = 1; k <= 4; k++) begin
      do_instr(1, 6'h02, 0, 0, c);
      chk("nohs_j_cycles", c, 3);
      chk("wrap_retired", ret1, (1 + k) % 4);
    end

    op_in[1] = 6'h3F;
    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
